// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state codes,
// load/store select codes and the default watchdog limit.
package mem_arbiter_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_I_ACC = 2'd1;
  localparam logic [1:0] ST_D_ACC = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // D-side access select; matches the control FSM's dmsel encoding
  localparam logic [1:0] DM_LW = 2'b00;
  localparam logic [1:0] DM_LB = 2'b01;
  localparam logic [1:0] DM_SB = 2'b10;
  localparam logic [1:0] DM_SW = 2'b11;

  // Default number of cycles to wait for mready before aborting
  localparam int TIMEOUT_DEFAULT = 15;

  // Word accesses (lw/sw) must be naturally aligned; byte accesses never fault
  function automatic logic dsel_is_word(input logic [1:0] sel);
    return (sel == DM_LW) || (sel == DM_SW);
  endfunction

  // Stores are the codes with the upper bit set
  function automatic logic dsel_is_store(input logic [1:0] sel);
    return sel[1];
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: store byte enables / write-data
// replication, and lb byte extraction with sign extension.
module mem_byte_lane
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  st_lane,
  input  logic [1:0]  st_dsel,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_out,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_byte_sext
);

  logic [7:0] ld_byte;

  // Byte enables and write data for the access being granted
  always_comb begin
    st_be        = 4'b1111;
    st_wdata_out = 32'h0;
    case (st_dsel)
      DM_SB: begin
        // One-hot lane, little-endian (lane 0 = bits 7:0); the byte is
        // replicated so the memory can pick it up from any lane.
        st_be        = 4'b0001 << st_lane;
        st_wdata_out = {4{st_wdata[7:0]}};
      end
      DM_SW: begin
        st_be        = 4'b1111;
        st_wdata_out = st_wdata;
      end
      default: begin
        // Loads read the full word; lb picks its byte afterwards
        st_be        = 4'b1111;
        st_wdata_out = 32'h0;
      end
    endcase
  end

  // Select the addressed byte of the returned word and sign-extend it
  always_comb begin
    ld_byte = 8'h0;
    case (ld_lane)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_byte_sext = {{24{ld_byte[7]}}, ld_byte};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter shared by instruction fetch (I-side)
// and load/store (D-side). Alternating priority on contention, one access
// in flight, per-access timeout watchdog, one-cycle response pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic          ivalid,
  output logic [31:0]   irdata,
  output logic          ierr,
  input  logic          dreq,
  input  logic [AW-1:0] daddr,
  input  logic [1:0]    dsel,
  input  logic [31:0]   dwdata,
  output logic          dvalid,
  output logic [31:0]   drdata,
  output logic          derr,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [31:0]   mwdata,
  output logic [3:0]    mbe,
  input  logic [31:0]   mrdata,
  input  logic          mready
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]    state_q,  state_d;
  logic [7:0]    cnt_q,    cnt_d;
  logic          last_d_q, last_d_d;   // 1 when the D-side won the last grant
  logic          side_q,   side_d;     // side being served: 1 = D, 0 = I
  logic [1:0]    dsel_q,   dsel_d;
  logic [1:0]    lane_q,   lane_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic [3:0]    mbe_q,    mbe_d;
  logic          mwe_q,    mwe_d;
  logic [31:0]   irdata_q, irdata_d;
  logic          ierr_q,   ierr_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          derr_q,   derr_d;

  logic          grant_to_d;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lb_data;
  logic [31:0]   dload_data;

  mem_byte_lane u_lane (
    .st_lane      (daddr[1:0]),
    .st_dsel      (dsel),
    .st_wdata     (dwdata),
    .st_be        (lane_be),
    .st_wdata_out (lane_wdata),
    .ld_lane      (lane_q),
    .ld_rdata     (mrdata),
    .ld_byte_sext (lb_data)
  );

  // D-side result for a completed access; stores return zero
  always_comb begin
    dload_data = 32'h0;
    case (dsel_q)
      DM_LW:   dload_data = mrdata;
      DM_LB:   dload_data = lb_data;
      default: dload_data = 32'h0;
    endcase
  end

  // Next-state: arbitration, access setup, ready/timeout handling
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d_d   = last_d_q;
    side_d     = side_q;
    dsel_d     = dsel_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    mwdata_d   = mwdata_q;
    mbe_d      = mbe_q;
    mwe_d      = mwe_q;
    irdata_d   = irdata_q;
    ierr_d     = ierr_q;
    drdata_d   = drdata_q;
    derr_d     = derr_q;
    grant_to_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (ireq || dreq) begin
          // On contention serve whichever side did not win last time
          grant_to_d = dreq && (!ireq || !last_d_q);
          last_d_d   = grant_to_d;
          side_d     = grant_to_d;
          if (grant_to_d) begin
            addr_d   = {daddr[AW-1:2], 2'b00};
            dsel_d   = dsel;
            lane_d   = daddr[1:0];
            mwe_d    = dsel_is_store(dsel);
            mbe_d    = lane_be;
            mwdata_d = lane_wdata;
            if (dsel_is_word(dsel) && (daddr[1:0] != 2'b00)) begin
              // Misaligned word access never reaches memory
              state_d  = ST_RESP;
              derr_d   = 1'b1;
              drdata_d = 32'h0;
            end else begin
              state_d = ST_D_ACC;
            end
          end else begin
            addr_d   = {iaddr[AW-1:2], 2'b00};
            dsel_d   = DM_LW;
            lane_d   = 2'b00;
            mwe_d    = 1'b0;
            mbe_d    = 4'b1111;
            mwdata_d = 32'h0;
            if (iaddr[1:0] != 2'b00) begin
              // Fetches are word reads, so they fault the same way
              state_d  = ST_RESP;
              ierr_d   = 1'b1;
              irdata_d = 32'h0;
            end else begin
              state_d = ST_I_ACC;
            end
          end
        end
      end

      ST_I_ACC, ST_D_ACC: begin
        cnt_d = cnt_q + 8'd1;
        // mready wins even on the cycle the watchdog would expire
        if (mready) begin
          state_d = ST_RESP;
          if (state_q == ST_D_ACC) begin
            drdata_d = dload_data;
            derr_d   = 1'b0;
          end else begin
            irdata_d = mrdata;
            ierr_d   = 1'b0;
          end
        end else if (cnt_d == TIMEOUT_CNT) begin
          state_d = ST_RESP;
          if (state_q == ST_D_ACC) begin
            drdata_d = 32'h0;
            derr_d   = 1'b1;
          end else begin
            irdata_d = 32'h0;
            ierr_d   = 1'b1;
          end
        end
      end

      default: begin
        // ST_RESP: single pulse cycle, then back to arbitration
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      last_d_q <= 1'b0;
      side_q   <= 1'b0;
      dsel_q   <= DM_LW;
      lane_q   <= 2'b00;
      addr_q   <= '0;
      mwdata_q <= 32'h0;
      mbe_q    <= 4'b0000;
      mwe_q    <= 1'b0;
      irdata_q <= 32'h0;
      ierr_q   <= 1'b0;
      drdata_q <= 32'h0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
      side_q   <= side_d;
      dsel_q   <= dsel_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      mwe_q    <= mwe_d;
      irdata_q <= irdata_d;
      ierr_q   <= ierr_d;
      drdata_q <= drdata_d;
      derr_q   <= derr_d;
    end
  end

  assign mreq   = (state_q == ST_I_ACC) || (state_q == ST_D_ACC);
  assign mwe    = mwe_q && (state_q == ST_D_ACC);
  assign maddr  = addr_q;
  assign mwdata = mwdata_q;
  assign mbe    = mbe_q;

  assign ivalid = (state_q == ST_RESP) && !side_q;
  assign dvalid = (state_q == ST_RESP) && side_q;
  assign irdata = irdata_q;
  assign ierr   = ierr_q;
  assign drdata = drdata_q;
  assign derr   = derr_q;

endmodule
